// File: rtl/iter_shift_unit.sv
// ---------------------------------------------------------------------------
// iter_shift_unit
//
// Multi-cycle shift execution unit. Performs SLL / SRL / SRA / ROTR on a
// 32-bit operand by a 5-bit amount, moving at most STEP bits per cycle, and
// signals progress with a start/busy/done handshake so the multicycle
// controller can stall while the unit runs.
//
// Parameters:
//   STEP     maximum bits shifted per SHIFT cycle (1, 2, 4 or 8)
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset_n  synchronous active-low reset
//   flush    synchronous abort of the in-flight operation
//   start    begin an operation (accepted when not busy)
//   op       00 SLL, 01 SRL, 11 SRA, 10 ROTR
//   a        operand, sampled on the accepting edge
//   shamt    shift amount 0..31, sampled on the accepting edge
//   busy     high while shifting
//   done     one-cycle pulse, y holds a new result
//   y        result register
// ---------------------------------------------------------------------------
module iter_shift_unit #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);

    localparam logic [4:0] StepMax = 5'(STEP);

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpRotr = 2'b10;
    localparam logic [1:0] OpSra  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] y_q, y_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  count_q, count_d;

    logic [4:0]  step;
    logic [31:0] shifted;

    // Never shift past the remaining count, so count cannot underflow.
    always_comb begin
        step = (count_q < StepMax) ? count_q : StepMax;
    end

    always_comb begin
        shifted = work_q;
        unique case (op_q)
            OpSll:  shifted = work_q << step;
            OpSrl:  shifted = work_q >> step;
            OpSra:  shifted = 32'($signed(work_q) >>> step);
            // A left shift by 32 (step==0) yields zero, leaving work unchanged.
            OpRotr: shifted = (work_q >> step) | (work_q << (6'd32 - {1'b0, step}));
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        y_d     = y_q;
        op_d    = op_q;
        count_d = count_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    work_d  = a;
                    op_d    = op;
                    count_d = shamt;
                    if (shamt == 5'd0) begin
                        y_d     = a;
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d  = shifted;
                count_d = count_q - step;
                if (count_q == step) begin
                    y_d     = shifted;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush beats start and suppresses any result update on this edge.
        if (flush) begin
            state_d = StIdle;
            count_d = 5'd0;
            y_d     = y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            work_q  <= 32'h0;
            y_q     <= 32'h0;
            op_q    <= 2'b00;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            y_q     <= y_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign y    = y_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_shift_unit
//
// Drives four instances (STEP = 1, 2, 4, 8) from shared inputs and checks
// results, done latency, busy windows, flush, ignored starts and reset.
// ---------------------------------------------------------------------------
module tb_iter_shift_unit;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;

    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [31:0] y_v [4];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    iter_shift_unit #(.STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0])
    );
    iter_shift_unit #(.STEP(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1])
    );
    iter_shift_unit #(.STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2])
    );
    iter_shift_unit #(.STEP(8)) u_s8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy_v[3]), .done(done_v[3]), .y(y_v[3])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] va, input logic [1:0] vop,
                                              input logic [4:0] vsh);
        case (vop)
            2'b00:   return va << vsh;
            2'b01:   return va >> vsh;
            2'b11:   return 32'($signed(va) >>> vsh);
            default: return (vsh == 5'd0) ? va : ((va >> vsh) | (va << (32 - int'(vsh))));
        endcase
    endfunction

    function automatic int exp_lat(input int k, input logic [4:0] vsh);
        int s;
        s = 1 << k;
        return 1 + (int'(vsh) + s - 1) / s;
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (busy_v == 4'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation to all instances and check result and latency of each.
    task automatic run_all(input logic [31:0] ta, input logic [1:0] top, input logic [4:0] tsh,
                           input logic [31:0] ey, input bit chk_busy);
        int lat [4];
        int extra [4];
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            lat[k]   = 0;
            extra[k] = 0;
        end
        a     = ta;
        op    = top;
        shamt = tsh;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (done_v[k]) begin
                    if (lat[k] == 0) lat[k] = cyc;
                    else extra[k]++;
                end
                if (chk_busy)
                    check_eq($sformatf("busy_s%0d_c%0d", 1 << k, cyc), 32'(busy_v[k]),
                             32'(cyc < exp_lat(k, tsh)));
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("y_s%0d", 1 << k), y_v[k], ey);
            check_eq($sformatf("lat_s%0d", 1 << k), 32'(lat[k]), 32'(exp_lat(k, tsh)));
            check_eq($sformatf("xdone_s%0d", 1 << k), 32'(extra[k]), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        logic [31:0] ra;
        logic [1:0]  rop;
        logic [4:0]  rsh;

        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = 32'h0;
        shamt   = 5'd0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_busy", 32'(busy_v[k]), 32'd0);
            check_eq("rst_done", 32'(done_v[k]), 32'd0);
            check_eq("rst_y", y_v[k], 32'h0);
        end

        // Directed vectors with hand-computed results
        run_all(32'h8000_00F0, 2'b11, 5'd4,  32'hF800_000F, 1'b1);
        run_all(32'h1234_5678, 2'b00, 5'd0,  32'h1234_5678, 1'b1);
        run_all(32'h0000_00FF, 2'b10, 5'd9,  32'h7F80_0000, 1'b1);
        run_all(32'h8765_4321, 2'b10, 5'd16, 32'h4321_8765, 1'b0);
        run_all(32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000, 1'b0);
        run_all(32'h7000_0000, 2'b11, 5'd31, 32'h0000_0000, 1'b0);

        // Back-to-back on STEP=2: second start lands in the done cycle
        wait_idle();
        a = 32'hFFFF_FFFF; op = 2'b01; shamt = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        cnt  = 1;
        seen = 1'b0;
        while (cnt <= 40) begin
            if (done_v[1]) begin
                seen = 1'b1;
                break;
            end
            tick();
            cnt++;
        end
        check_eq("b2b_seen1", 32'(seen), 32'd1);
        check_eq("b2b_lat1", 32'(cnt), 32'd17);
        check_eq("b2b_y1", y_v[1], 32'h0000_0001);
        a = 32'h0000_0001; op = 2'b00; shamt = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b2b_busy", 32'(busy_v[1]), 32'd1);
        cnt  = 1;
        seen = 1'b0;
        while (cnt <= 40) begin
            if (done_v[1]) begin
                seen = 1'b1;
                break;
            end
            tick();
            cnt++;
        end
        check_eq("b2b_seen2", 32'(seen), 32'd1);
        check_eq("b2b_lat2", 32'(cnt), 32'd17);
        check_eq("b2b_y2", y_v[1], 32'h8000_0000);
        for (int i = 0; i < 34; i++) tick();

        // Known result in every instance before the flush test
        run_all(32'hA5A5_0000, 2'b01, 5'd4, 32'h0A5A_5000, 1'b0);

        // Flush mid-shift, with a start on the same edge
        a = 32'h0000_FFFF; op = 2'b00; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("flush_busy", 32'(busy_v[k]), 32'd0);
            check_eq("flush_y", y_v[k], 32'h0A5A_5000);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_v != 4'b0) cnt++;
            tick();
        end
        check_eq("flush_nodone", 32'(cnt), 32'd0);

        // Start while busy is ignored (STEP 1/2/4 are still shifting)
        a = 32'h0000_0001; op = 2'b00; shamt = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'hFFFF_FFFF; op = 2'b01; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("ign_y_s%0d", 1 << k), y_v[k], 32'h0000_0100);
        check_eq("ign_y_s8", y_v[3], 32'h7FFF_FFFF);

        // Randomised operations against the reference formula
        for (int n = 0; n < 300; n++) begin
            ra  = $urandom;
            rop = 2'($urandom_range(0, 3));
            rsh = 5'($urandom_range(0, 31));
            run_all(ra, rop, rsh, ref_shift(ra, rop, rsh), 1'b0);
        end

        // Reset in the middle of a long STEP=1 shift
        wait_idle();
        a = 32'hDEAD_BEEF; op = 2'b00; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("mrst_busy", 32'(busy_v[k]), 32'd0);
            check_eq("mrst_done", 32'(done_v[k]), 32'd0);
            check_eq("mrst_y", y_v[k], 32'h0);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_v != 4'b0) cnt++;
            tick();
        end
        check_eq("mrst_nodone", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
